stream_loader: RTL
==================

# stream_loader

Downstream stage of the AXI-Lite control block. It consumes the 2-bit control state and an AXI-Stream from the DMA engine. While the control state is PARAM_LOAD or IMAGE_LOAD, it writes incoming words into the parameter buffer or the image buffer. When a load is complete it raises the state-convert request that returns the control block to IDLE.

## Interface
Parameters:
- DATA_W, 32, stream and buffer word width
- PARAM_DEPTH, 256, words per parameter load (≥2)
- IMAGE_DEPTH, 1024, words per image load (≥2)

Ports:
- clk  in  1  single clock
- rstn  in  1  reset, asynchronous, active-low
- i_state  in  2  control state: 0 IDLE, 1 PARAM_LOAD, 2 IMAGE_LOAD, 3 START_ACCEL
- o_state_cnvt  out  1  load-complete request to the control block
- s_axis_tdata  in  DATA_W  stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  stream last
- o_param_we / o_param_addr / o_param_wdata  out  1 / $clog2(PARAM_DEPTH) / DATA_W  parameter buffer write port
- o_img_we / o_img_addr / o_img_wdata  out  1 / $clog2(IMAGE_DEPTH) / DATA_W  image buffer write port
- o_param_valid  out  1  sticky: a full parameter set is loaded
- o_busy  out  1  high in S_PARAM or S_IMAGE
- o_err  out  1  sticky framing error (present only with the macro; see Configuration)

## Operation
FSM states and transitions:
- S_IDLE: i_state==1 → S_PARAM; i_state==2 → S_IMAGE. Entering either state clears the beat counter. i_state 0 or 3 → stay in S_IDLE.
- S_PARAM / S_IMAGE: s_axis_tready=1.
  - Each beat (tvalid&tready) writes tdata at addr=counter, then increments the counter.
  - The beat with counter==DEPTH-1 → S_DONE.
  - In S_PARAM, that final beat also sets o_param_valid.
- S_DONE: o_state_cnvt=1 (level), tready=0. Hold until i_state==0, then → S_IDLE. The level hold guarantees the request is seen even if a register write lands on the same cycle.
- Abort: i_state==0 while in S_PARAM/S_IMAGE → S_IDLE. Counter cleared; the current-cycle beat is not accepted; o_param_valid is unchanged.
- Parameter load start clears o_param_valid. Image loads do not touch it.
- Counter is DEPTH-bounded and never wraps. The beat after DEPTH-1 is never accepted.

## Timing
- All outputs are registered. Reset values: o_state_cnvt=0, s_axis_tready=0, we=0, addr=0, wdata=0, o_param_valid=0, o_busy=0, o_err=0. FSM resets to S_IDLE.
- s_axis_tready rises 1 cycle after i_state becomes 1 or 2.
- Write latency: a beat accepted at cycle t drives we/addr/wdata at t+1, with we high for exactly one cycle per beat.
- A final beat accepted at t gives tready=0 and o_state_cnvt=1 from t+1.
- o_state_cnvt falls 1 cycle after i_state==0 is sampled.
- Back-to-back beats give one write per cycle with no bubbles.
- Reset asserted mid-load aborts immediately; all outputs return to their reset values asynchronously.

## Configuration
- STREAM_LOADER_TLAST_CHECK_EN defined:
  - tlast on a beat with counter!=DEPTH-1 sets o_err and ends the load (→ S_DONE).
  - Missing tlast on the DEPTH-1 beat sets o_err; the load still completes.
  - o_err clears only on reset.
- Undefined: tlast is ignored, loads are purely count-based, and o_err is tied to 0.

## Structure
- Shared package stream_loader_pkg: control-state encodings (IDLE, PARAM_LOAD, IMAGE_LOAD, START_ACCEL), which are shared with the control block, plus the FSM state encodings.
- One sub-module is natural: stream_beat_cnt, a bounded counter with clear, enable, and terminal-count flag, parameterized by depth. It is used once; the depth is selected by FSM state.

## Test plan
- Parameter load, PARAM_DEPTH=4, i_state=1, beats 0xA0..0xA3 with tlast on the 4th → param writes at addr 0..3 with matching data; o_state_cnvt=1 the cycle after the 4th beat; o_param_valid=1; with i_state=0, o_state_cnvt falls next cycle.
- Image load, IMAGE_DEPTH=8, with tvalid toggling every other cycle → 8 img writes, addresses 0..7 in order; tready=0 after the 8th beat; no param writes.
- Abort: i_state=0 after 3 of 8 image beats → S_IDLE, tready=0, no o_state_cnvt. A following image load restarts at addr 0.
- Overrun: 6 valid beats offered with PARAM_DEPTH=4 → only 4 accepted; beats 5 and 6 remain stalled with tready=0.
- With the macro defined, early tlast on the 2nd of 4 beats → o_err=1 and o_state_cnvt=1; without the macro, the same stimulus → 4 beats accepted and o_err=0.
- Async reset pulse mid-load at beat 2 → all outputs at reset values within the reset cycle; o_param_valid=0.

Source files
------------

// File: rtl/stream_loader_pkg.sv
// -----------------------------------------------------------------------------
// stream_loader_pkg
//   Shared encodings for the stream loader and the AXI-Lite control block.
//   - ctrl_state_e : 2-bit control state published by the control block
//   - load_state_e : internal FSM states of stream_loader
//   - is_load_state: helper, true while a load is accepting beats
// -----------------------------------------------------------------------------
package stream_loader_pkg;

  // Control-state encoding shared with the control block.
  typedef enum logic [1:0] {
    CTRL_IDLE        = 2'd0,
    CTRL_PARAM_LOAD  = 2'd1,
    CTRL_IMAGE_LOAD  = 2'd2,
    CTRL_START_ACCEL = 2'd3
  } ctrl_state_e;

  // Loader FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PARAM = 2'd1,
    S_IMAGE = 2'd2,
    S_DONE  = 2'd3
  } load_state_e;

  // True in the states where the stream is being consumed.
  function automatic logic is_load_state(load_state_e st);
    return (st == S_PARAM) || (st == S_IMAGE);
  endfunction

endpackage

// File: rtl/stream_beat_cnt.sv
// -----------------------------------------------------------------------------
// stream_beat_cnt
//   Bounded beat counter. Counts accepted beats from 0 up to a terminal value
//   chosen at run time and saturates there; it never wraps.
//   Ports:
//     clk, rstn : clock, asynchronous active-low reset
//     clr_i     : synchronous clear to 0 (has priority over en_i)
//     en_i      : count one beat
//     last_i    : terminal value (DEPTH-1 of the active buffer)
//     cnt_o     : current count (registered)
//     tc_o      : terminal-count flag, cnt_o == last_i
// -----------------------------------------------------------------------------
module stream_beat_cnt #(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] last_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tc_s;

  assign tc_s  = (cnt_q == last_i);
  assign tc_o  = tc_s;
  assign cnt_o = cnt_q;

  // Next count: clear wins, otherwise increment unless already at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stream_loader.sv
// -----------------------------------------------------------------------------
// stream_loader
//   Consumes the control state and an AXI-Stream from the DMA engine. During
//   PARAM_LOAD / IMAGE_LOAD, stream words are written into the parameter or
//   image buffer at consecutive addresses. When the buffer is full the loader
//   holds o_state_cnvt high until the control block returns to IDLE.
//
//   Optional feature macro: STREAM_LOADER_TLAST_CHECK_EN
//     defined   : tlast framing is checked; early tlast ends the load, missing
//                 tlast on the last beat is flagged; o_err is sticky to reset.
//     undefined : tlast is ignored, o_err is tied low.
//
//   Ports:
//     clk, rstn                     clock, asynchronous active-low reset
//     i_state                       control state (ctrl_state_e)
//     o_state_cnvt                  load-complete request (level)
//     s_axis_tdata/tvalid/tready/tlast   input stream
//     o_param_we/addr/wdata         parameter buffer write port
//     o_img_we/addr/wdata           image buffer write port
//     o_param_valid                 sticky: full parameter set loaded
//     o_busy                        loader is consuming a stream
//     o_err                         sticky framing error
//   All outputs are registered.
// -----------------------------------------------------------------------------
module stream_loader
  import stream_loader_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PARAM_DEPTH = 256,
  parameter int unsigned IMAGE_DEPTH = 1024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [1:0]                     i_state,
  output logic                           o_state_cnvt,
  input  logic [DATA_W-1:0]              s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic                           o_param_we,
  output logic [$clog2(PARAM_DEPTH)-1:0] o_param_addr,
  output logic [DATA_W-1:0]              o_param_wdata,
  output logic                           o_img_we,
  output logic [$clog2(IMAGE_DEPTH)-1:0] o_img_addr,
  output logic [DATA_W-1:0]              o_img_wdata,
  output logic                           o_param_valid,
  output logic                           o_busy,
  output logic                           o_err
);

  localparam int unsigned PARAM_AW = $clog2(PARAM_DEPTH);
  localparam int unsigned IMG_AW   = $clog2(IMAGE_DEPTH);
  localparam int unsigned CNT_W    = (PARAM_AW > IMG_AW) ? PARAM_AW : IMG_AW;
  localparam logic [CNT_W-1:0] PARAM_LAST = CNT_W'(PARAM_DEPTH - 1);
  localparam logic [CNT_W-1:0] IMG_LAST   = CNT_W'(IMAGE_DEPTH - 1);

  // FSM and output registers
  load_state_e         state_q, state_d;
  logic                tready_q, tready_d;
  logic                busy_q, busy_d;
  logic                cnvt_q, cnvt_d;
  logic                param_we_q, param_we_d;
  logic [PARAM_AW-1:0] param_addr_q, param_addr_d;
  logic [DATA_W-1:0]   param_wdata_q, param_wdata_d;
  logic                img_we_q, img_we_d;
  logic [IMG_AW-1:0]   img_addr_q, img_addr_d;
  logic [DATA_W-1:0]   img_wdata_q, img_wdata_d;
  logic                param_valid_q, param_valid_d;

  // Combinational helpers
  ctrl_state_e         ctrl_s;
  logic                accept_s;
  logic                early_end_s;
  logic                cnt_clr_s;
  logic                cnt_en_s;
  logic [CNT_W-1:0]    cnt_s;
  logic [CNT_W-1:0]    last_s;
  logic                tc_s;

  assign ctrl_s = ctrl_state_e'(i_state);

  // A beat is taken only in a load state and only when the control block has
  // not just dropped back to IDLE; an abort cycle swallows no data.
  assign accept_s = s_axis_tvalid & tready_q & is_load_state(state_q)
                  & (ctrl_s != CTRL_IDLE);

  // The active buffer decides where the counter stops.
  assign last_s = (state_q == S_IMAGE) ? IMG_LAST : PARAM_LAST;

`ifdef STREAM_LOADER_TLAST_CHECK_EN
  assign early_end_s = s_axis_tlast & ~tc_s;
`else
  logic unused_tlast_s;
  assign unused_tlast_s = s_axis_tlast;
  assign early_end_s    = 1'b0;
`endif

  stream_beat_cnt #(
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (cnt_clr_s),
    .en_i   (cnt_en_s),
    .last_i (last_s),
    .cnt_o  (cnt_s),
    .tc_o   (tc_s)
  );

  // Next-state, write-port and status logic.
  always_comb begin
    state_d       = state_q;
    cnt_clr_s     = 1'b0;
    cnt_en_s      = 1'b0;
    param_we_d    = 1'b0;
    param_addr_d  = param_addr_q;
    param_wdata_d = param_wdata_q;
    img_we_d      = 1'b0;
    img_addr_d    = img_addr_q;
    img_wdata_d   = img_wdata_q;
    param_valid_d = param_valid_q;

    case (state_q)
      S_IDLE: begin
        // Counter is held at zero so every load starts at address 0.
        cnt_clr_s = 1'b1;
        case (ctrl_s)
          CTRL_PARAM_LOAD: begin
            state_d       = S_PARAM;
            param_valid_d = 1'b0;
          end
          CTRL_IMAGE_LOAD: begin
            state_d = S_IMAGE;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end

      S_PARAM, S_IMAGE: begin
        if (ctrl_s == CTRL_IDLE) begin
          state_d   = S_IDLE;
          cnt_clr_s = 1'b1;
        end else if (accept_s) begin
          cnt_en_s = 1'b1;
          if (state_q == S_PARAM) begin
            param_we_d    = 1'b1;
            param_addr_d  = cnt_s[PARAM_AW-1:0];
            param_wdata_d = s_axis_tdata;
          end else begin
            img_we_d    = 1'b1;
            img_addr_d  = cnt_s[IMG_AW-1:0];
            img_wdata_d = s_axis_tdata;
          end
          if (tc_s || early_end_s) begin
            state_d = S_DONE;
          end else begin
            state_d = state_q;
          end
          // Only a count-complete parameter load is a valid set.
          if (tc_s && (state_q == S_PARAM)) begin
            param_valid_d = 1'b1;
          end else begin
            param_valid_d = param_valid_q;
          end
        end else begin
          state_d = state_q;
        end
      end

      S_DONE: begin
        if (ctrl_s == CTRL_IDLE) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Stream-side outputs follow the next state so they are registered yet
    // line up with the state they describe.
    tready_d = is_load_state(state_d);
    busy_d   = is_load_state(state_d);
    cnvt_d   = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      tready_q      <= 1'b0;
      busy_q        <= 1'b0;
      cnvt_q        <= 1'b0;
      param_we_q    <= 1'b0;
      param_addr_q  <= '0;
      param_wdata_q <= '0;
      img_we_q      <= 1'b0;
      img_addr_q    <= '0;
      img_wdata_q   <= '0;
      param_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tready_q      <= tready_d;
      busy_q        <= busy_d;
      cnvt_q        <= cnvt_d;
      param_we_q    <= param_we_d;
      param_addr_q  <= param_addr_d;
      param_wdata_q <= param_wdata_d;
      img_we_q      <= img_we_d;
      img_addr_q    <= img_addr_d;
      img_wdata_q   <= img_wdata_d;
      param_valid_q <= param_valid_d;
    end
  end

`ifdef STREAM_LOADER_TLAST_CHECK_EN
  logic err_q, err_d;

  // Framing error: tlast before the last beat, or no tlast on the last beat.
  always_comb begin
    err_d = err_q;
    if (accept_s && (early_end_s || (tc_s && !s_axis_tlast))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Sticky error register, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_state_cnvt  = cnvt_q;
  assign s_axis_tready = tready_q;
  assign o_param_we    = param_we_q;
  assign o_param_addr  = param_addr_q;
  assign o_param_wdata = param_wdata_q;
  assign o_img_we      = img_we_q;
  assign o_img_addr    = img_addr_q;
  assign o_img_wdata   = img_wdata_q;
  assign o_param_valid = param_valid_q;
  assign o_busy        = busy_q;

endmodule
